// File: rtl/multicycle_ctrl_fsm_pkg.sv
// ctrl_pkg: shared state, opcode and datapath-select encodings for the multi-cycle control FSM.
package ctrl_pkg;
    typedef enum logic [3:0] {S_RST, S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP, S_HALT} state_t;
    localparam int unsigned OP_ALU  = 0;
    localparam int unsigned OP_IMM  = 1;
    localparam int unsigned OP_LW   = 2;
    localparam int unsigned OP_SW   = 3;
    localparam int unsigned OP_BR   = 4;
    localparam int unsigned OP_BLTZ = 5;
    localparam int unsigned OP_BZ   = 6;
    localparam int unsigned OP_BNZ  = 7;
    localparam int unsigned OP_B    = 8;
    localparam int unsigned OP_BL   = 9;
    localparam int unsigned OP_BCY  = 10;
    localparam int unsigned OP_BNCY = 11;
    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REG   = 2'b01;
    localparam logic [1:0] PC_IMM   = 2'b10;
    localparam logic [1:0] PC_TRAP  = 2'b11;
    localparam logic [1:0] RD_RD    = 2'b00;
    localparam logic [1:0] RD_RT    = 2'b01;
    localparam logic [1:0] RD_LINK  = 2'b10;
    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MEM  = 2'b01;
    localparam logic [1:0] M2R_PC   = 2'b10;
    localparam logic [1:0] ALU_R    = 2'd0;
    localparam logic [1:0] ALU_IMM  = 2'd1;
    localparam logic [1:0] ALU_ADDR = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;
endpackage

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// mem_wait_timer: counts consecutive stalled memory-request cycles and flags the one that hits the limit.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ready,
    output logic timeout
);
    localparam int W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LIM = W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
    logic [W-1:0] count;
    // The stall that would bring the count to the limit is the timeout; a ready in that cycle wins.
    assign timeout = (MEM_TIMEOUT > 0) && req && !ready && count == LIM;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else count <= (req && !ready && !timeout) ? count + 1'b1 : '0;
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: IF/ID/EX/MEM/WB control sequencer with memory handshake and stall timeout.
// Define ILLEGAL_TRAP_EN to send unknown opcodes through S_TRAP instead of treating them as NOPs.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                flag_zero,
    input  logic                flag_sign,
    input  logic                flag_carry,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                alu_src,
    output logic                mem_err,
    output logic                halted,
    output logic [3:0]          state_o
);
`ifdef ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = S_TRAP;
`else
    localparam state_t ILL_NEXT = S_IF;
`endif
    state_t state, next;
    logic [OPCODE_W-1:0] op_q;
    logic [31:0] op;
    logic timeout, taken;
    logic [1:0] alu_code;
    assign op       = 32'(op_q);
    assign mem_req  = state == S_IF || state == S_MEM;
    assign addr_sel = state == S_MEM;
    assign mem_we   = state == S_MEM && op == OP_SW;
    assign halted   = state == S_HALT;
    assign state_o  = state;
    assign alu_op   = ALUOP_W'(alu_code);
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk(clk), .rst_n(rst_n), .req(mem_req), .ready(mem_ready), .timeout(timeout)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RST;
            op_q    <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= next;
            op_q    <= state == S_ID ? opcode : op_q;
            mem_err <= mem_err | timeout;
        end
    end
    always_comb begin
        case (op)
            OP_BR, OP_B, OP_BL: taken = 1'b1;
            OP_BLTZ:            taken = flag_sign;
            OP_BZ:              taken = flag_zero;
            OP_BNZ:             taken = !flag_zero;
            OP_BCY:             taken = flag_carry;
            OP_BNCY:            taken = !flag_carry;
            default:            taken = 1'b0;
        endcase
    end
    always_comb begin
        next       = state;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        reg_write  = 1'b0;
        reg_dst    = RD_RD;
        mem_to_reg = M2R_ALU;
        alu_code   = ALU_R;
        alu_src    = 1'b0;
        case (state)
            S_RST: next = S_IF;
            S_IF: begin
                ir_write = mem_ready;
                pc_write = mem_ready;
                next     = timeout ? S_HALT : mem_ready ? S_ID : S_IF;
            end
            S_ID: next = 32'(opcode) <= OP_BNCY ? S_EX : ILL_NEXT;
            S_EX: begin
                alu_code = op == OP_ALU ? ALU_R : op == OP_IMM ? ALU_IMM : op <= OP_SW ? ALU_ADDR : ALU_PASS;
                alu_src  = op == OP_IMM || op == OP_LW || op == OP_SW;
                pc_write = taken;
                pc_src   = !taken ? PC_PLUS4 : op == OP_BR ? PC_REG : PC_IMM;
                next     = (op <= OP_IMM || op == OP_BL) ? S_WB : op <= OP_SW ? S_MEM : S_IF;
            end
            S_MEM: next = timeout ? S_HALT : !mem_ready ? S_MEM : op == OP_LW ? S_WB : S_IF;
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = op == OP_LW ? RD_RT : op == OP_BL ? RD_LINK : RD_RD;
                mem_to_reg = op == OP_LW ? M2R_MEM : op == OP_BL ? M2R_PC : M2R_ALU;
                next       = S_IF;
            end
            S_TRAP: begin
                pc_write = 1'b1;
                pc_src   = PC_TRAP;
                next     = S_IF;
            end
            default: next = S_HALT;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: instruction-level model expanded to per-cycle expected strobes, plus literal timing pins.
module tb_multicycle_ctrl_fsm;
    typedef struct {
        logic       rdy, fz, fs, fc;
        logic [5:0] op;
        logic [18:0] exp;
    } ent_t;
    logic clk = 0, rst_n = 1;
    logic [5:0] opcode = 0;
    logic mem_ready = 0, flag_zero = 0, flag_sign = 0, flag_carry = 0;
    logic mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write, alu_src, mem_err, halted;
    logic [1:0] pc_src, reg_dst, mem_to_reg;
    logic [3:0] alu_op, state_o, s_snap;
    logic [18:0] outv;
    int n_chk = 0, n_fail = 0, cyc = 0;
    ent_t sched[$];
    int fetch_cyc[$];
    logic err = 0, hlt = 0, c_fz = 0, c_fs = 0, c_fc = 0;
    logic [5:0] c_op = 0;
`ifdef ILLEGAL_TRAP_EN
    int exp_gap[14] = '{4, 4, 5, 4, 3, 3, 3, 4, 3, 3, 3, 3, 3, 3};
`else
    int exp_gap[14] = '{4, 4, 5, 4, 3, 3, 3, 4, 3, 3, 3, 3, 3, 2};
`endif
    multicycle_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .flag_zero(flag_zero), .flag_sign(flag_sign), .flag_carry(flag_carry),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_op(alu_op), .alu_src(alu_src), .mem_err(mem_err),
        .halted(halted), .state_o(state_o)
    );
    assign outv = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write,
                   reg_dst, mem_to_reg, alu_op, alu_src, mem_err, halted};
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    function automatic logic [18:0] ov(input int req, we, asel, irw, pcw, pcs, rw, rd, m2r, aop, asrc);
        return {req[0], we[0], asel[0], irw[0], pcw[0], pcs[1:0], rw[0], rd[1:0], m2r[1:0], aop[3:0], asrc[0], 2'b00};
    endfunction
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask
    task automatic put(input int rdy, input logic [18:0] e);
        ent_t x;
        x.rdy = rdy[0]; x.fz = c_fz; x.fs = c_fs; x.fc = c_fc; x.op = c_op;
        x.exp = e | {17'b0, err, hlt};
        sched.push_back(x);
    endtask
    // One instruction: iw stalled fetch cycles, mw stalled memory cycles, flags held for its duration.
    task automatic instr(input int op, input int iw, input int mw, input int fz, input int fs, input int fc);
        logic tk;
        c_op = op[5:0]; c_fz = fz[0]; c_fs = fs[0]; c_fc = fc[0];
        repeat (iw) put(0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        put(1, ov(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        put(0, '0);
        if (op > 11) begin
`ifdef ILLEGAL_TRAP_EN
            put(0, ov(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0));
`endif
            return;
        end
        if (op < 2) begin
            put(0, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, op, op));
            put(0, ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        end else if (op < 4) begin
            put(0, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
            repeat (mw) put(0, ov(1, int'(op == 3), 1, 0, 0, 0, 0, 0, 0, 0, 0));
            put(1, ov(1, int'(op == 3), 1, 0, 0, 0, 0, 0, 0, 0, 0));
            if (op == 2) put(0, ov(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        end else begin
            tk = op == 4 || op == 8 || op == 9 || (op == 5 && fs != 0) || (op == 6 && fz != 0) ||
                 (op == 7 && fz == 0) || (op == 10 && fc != 0) || (op == 11 && fc == 0);
            put(0, ov(0, 0, 0, 0, int'(tk), tk ? (op == 4 ? 1 : 2) : 0, 0, 0, 0, 3, 0));
            if (op == 9) put(0, ov(0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0));
        end
    endtask
    task automatic run();
        ent_t e;
        while (sched.size() > 0) begin
            e = sched.pop_front();
            @(posedge clk);
            #1;
            mem_ready = e.rdy; opcode = e.op; flag_zero = e.fz; flag_sign = e.fs; flag_carry = e.fc;
            @(negedge clk);
            check($sformatf("cycle%0d op%0h outputs", cyc, e.op), 32'(outv), 32'(e.exp));
            if (ir_write) fetch_cyc.push_back(cyc);
        end
        mem_ready = 0;
    endtask
    task automatic do_reset();
        rst_n = 0;
        mem_ready = 0;
        #1;
        check("reset_assert_outputs", 32'(outv), 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("s_rst_outputs", 32'(outv), 0);
        err = 0;
        hlt = 0;
    endtask
    initial begin
        #3;
        do_reset();
        fetch_cyc.delete();
        instr(0, 0, 0, 0, 0, 0);   instr(1, 0, 0, 0, 0, 0);   instr(2, 0, 0, 0, 0, 0);
        instr(3, 0, 0, 0, 0, 0);   instr(4, 0, 0, 0, 0, 0);   instr(6, 0, 0, 1, 0, 0);
        instr(6, 0, 0, 0, 0, 0);   instr(9, 0, 0, 0, 0, 0);   instr(5, 0, 0, 0, 1, 0);
        instr(7, 0, 0, 0, 0, 0);   instr(10, 0, 0, 0, 0, 0);  instr(11, 0, 0, 0, 0, 0);
        instr(8, 0, 0, 0, 0, 0);   instr(63, 0, 0, 0, 0, 0);  instr(0, 0, 0, 0, 0, 0);
        run();
        check("fetch_count", 32'(fetch_cyc.size()), 15);
        for (int i = 0; i < 14 && i + 1 < fetch_cyc.size(); i++)
            check($sformatf("instr%0d_cycles", i), 32'(fetch_cyc[i+1] - fetch_cyc[i]), 32'(exp_gap[i]));
        do_reset();
        instr(2, 0, 3, 0, 0, 0);
        instr(2, 15, 15, 0, 0, 0);
        instr(3, 0, 2, 0, 0, 0);
        instr(0, 0, 0, 0, 0, 0);
        run();
        check("no_err_after_ready_at_limit", 32'(mem_err), 0);
        do_reset();
        c_op = 0;
        repeat (16) put(0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        err = 1;
        hlt = 1;
        repeat (3) put(0, '0);
        repeat (2) put(1, '0);
        run();
        check("timeout_mem_err", 32'(mem_err), 1);
        check("timeout_halted", 32'(halted), 1);
        check("timeout_mem_req", 32'(mem_req), 0);
        s_snap = state_o;
        @(negedge clk);
        check("halt_state_stable", 32'(state_o), 32'(s_snap));
        do_reset();
        check("mem_err_cleared", 32'(mem_err), 0);
        c_op = 2;
        put(1, ov(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        put(0, '0);
        put(0, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
        repeat (2) put(0, ov(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run();
        check("pre_reset_mem_req", 32'({mem_req, addr_sel}), 3);
        do_reset();
        instr(1, 1, 0, 0, 0, 0);
        run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle successor to the single-cycle KGPminiRISC control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Generates per-state datapath strobes and handshakes with a variable-latency memory via req/ready.
- Resolves conditional branches from ALU/carry flags; guards memory stalls with a timeout.

Parameters:
- OPCODE_W, 6, instruction opcode width
- ALUOP_W, 4, width of alu_op
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  from instruction register; valid from ID onward
- mem_ready  in  1  memory completes current request this cycle
- flag_zero  in  1  ALU result zero (combinational, EX)
- flag_sign  in  1  ALU result negative (EX)
- flag_carry  in  1  registered carry flag
- mem_req  out  1  memory request
- mem_we  out  1  write qualifier for mem_req
- addr_sel  out  1  0 = PC address, 1 = ALU address
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  2  00 PC+4, 01 register (br), 10 PC+imm, 11 trap vector
- reg_write  out  1  register file write
- reg_dst  out  2  00 rd, 01 rt, 10 link reg (r31)
- mem_to_reg  out  2  00 ALU, 01 memory, 10 PC (link)
- alu_op  out  ALUOP_W  00 R-type, 01 immediate, 02 address add, 03 pass/compare
- alu_src  out  1  0 reg, 1 immediate
- mem_err  out  1  sticky; timeout occurred
- halted  out  1  FSM in S_HALT
- state_o  out  4  current state encoding, for debug

Behaviour:
- States: S_RST, S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP, S_HALT.
- Reset: async assert forces S_RST, clears op_q, the wait counter and mem_err. All outputs are 0 during reset and in S_RST.
- S_RST always goes to S_IF on the next clock.
- Outputs are a Moore decode of state and op_q; there is no combinational path from opcode to outputs.
- S_IF:
  - asserts mem_req, addr_sel=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00 in that same cycle, then go to S_ID.
  - Otherwise hold state.
- S_ID: latch opcode into op_q. Opcodes 0x00–0x0B go to S_EX; others go to S_TRAP or S_IF (see Optional Feature).
- S_EX:
  - alu_op/alu_src come from op_q.
  - 0x00: alu_op=0, alu_src=0. 0x01: alu_op=1, alu_src=1. Both then go to S_WB.
  - lw 0x02 / sw 0x03: alu_op=2, alu_src=1, then go to S_MEM.
  - Branches, all alu_op=3:
    - br 0x04: pc_write, pc_src=01.
    - bltz 0x05: taken when flag_sign.
    - bz 0x06: taken when flag_zero.
    - bnz 0x07: taken when !flag_zero.
    - b 0x08, bl 0x09: always taken.
    - bcy 0x0A: taken when flag_carry.
    - bncy 0x0B: taken when !flag_carry.
    - Taken conditional branches and b/bl: pc_write=1, pc_src=10. Not taken: no pc_write.
    - bl goes to S_WB; all other branches go to S_IF.
- S_MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for sw.
  - Hold until mem_ready; then lw goes to S_WB and sw goes to S_IF.
- S_WB: reg_write=1 for exactly one cycle, then S_IF.
  - ALU ops: reg_dst=00, mem_to_reg=00.
  - lw: reg_dst=01, mem_to_reg=01.
  - bl: reg_dst=10, mem_to_reg=10.
- Cycle counts with zero-wait memory:
  - ALU: 4.
  - lw: 5.
  - sw: 4.
  - Branch: 3.
  - bl: 4.
- Wait counter:
  - Counts consecutive cycles with mem_req=1 && !mem_ready; clears whenever mem_ready is 1 or mem_req is 0.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT: set mem_err, go to S_HALT, drop mem_req.
  - mem_ready arriving in the same cycle the count would reach the limit wins (no error).
- S_HALT: all strobes 0, halted=1; only reset exits.
- Reset mid-request: mem_req drops asynchronously; no partial writeback.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in S_ID goes to S_TRAP. S_TRAP asserts pc_write=1, pc_src=11 for one cycle, then goes to S_IF.
- Undefined: an unknown opcode is a NOP, going S_ID→S_IF with no writes. S_TRAP is unreachable.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum;
  - opcode constants OP_ALU..OP_BNCY;
  - pc_src, reg_dst and mem_to_reg encodings;
  - alu_op codes.
- One sub-module, mem_wait_timer: the wait counter and timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset release, opcode 0x00, mem_ready tied 1 → S_RST,IF,ID,EX,WB,IF. ir_write in cycle 2, reg_write only in cycle 5, reg_dst=00.
- lw (0x02), mem_ready low 3 cycles in S_MEM → mem_req held 4 cycles with addr_sel=1. WB follows with mem_to_reg=01, reg_dst=01.
- bz with flag_zero=1 → pc_write=1, pc_src=10 in EX. Repeat with flag_zero=0 → no pc_write in EX, 3-cycle instruction.
- bl (0x09) → pc_write in EX, then reg_write with reg_dst=10, mem_to_reg=10.
- MEM_TIMEOUT=16, mem_ready stuck 0 in IF → mem_err and halted after 16 req cycles; mem_req=0 thereafter until rst_n pulse.
- Opcode 0x3F → with ILLEGAL_TRAP_EN, one-cycle pc_write with pc_src=11; without it, return to IF with no strobes.
- Drop rst_n mid S_MEM → all outputs 0 immediately.
